// File: rtl/weight_bias_responder.sv
// Responder for the weight/bias read path: serialises requests onto the shared parameter SRAM.
// Optional per-channel last-word cache enabled by defining WB_LAST_CACHE_EN.
module weight_bias_responder #(
    parameter logic [15:0] BIAS_BASE = 16'h8000,
    parameter int          DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_weight_signal,
    input  logic [15:0]       read_weight_addr,
    input  logic              read_bias_signal,
    input  logic [15:0]       read_bias_addr,
    input  logic              layer_start,
    output logic              weight_ready,
    output logic              bias_ready,
    output logic [DATA_W-1:0] weight_data,
    output logic              weight_valid,
    output logic [DATA_W-1:0] bias_data,
    output logic              bias_valid,
    output logic              req_drop_err,
    output logic              mem_cs,
    output logic [15:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);
    // Handshake: a request is taken on a rising edge where signal && ready; a request
    // seen while ready is low is lost and latches req_drop_err until reset.
    logic              r_pend_w;
    logic              r_pend_b;
    logic [15:0]       r_addr_w;
    logic [15:0]       r_addr_b;
    logic              r_fetch_vld;
    logic              r_fetch_b;
    logic              w_grant_w;
    logic              w_grant_b;
    logic              w_acc_w;
    logic              w_acc_b;
    logic              w_ret_w;
    logic              w_ret_b;
    logic              w_hit_w;
    logic              w_hit_b;
    logic [DATA_W-1:0] w_cd_w;
    logic [DATA_W-1:0] w_cd_b;

    assign w_grant_b    = r_pend_b;
    assign w_grant_w    = r_pend_w & ~r_pend_b;
    assign mem_cs       = w_grant_w | w_grant_b;
    assign mem_addr     = w_grant_b ? (r_addr_b + BIAS_BASE) :
                          (w_grant_w ? r_addr_w : 16'h0000);
    assign weight_ready = ~r_pend_w | w_grant_w;
    assign bias_ready   = ~r_pend_b | w_grant_b;
    assign w_acc_w      = read_weight_signal & weight_ready;
    assign w_acc_b      = read_bias_signal & bias_ready;
    assign w_ret_w      = r_fetch_vld & ~r_fetch_b;
    assign w_ret_b      = r_fetch_vld & r_fetch_b;

`ifdef WB_LAST_CACHE_EN
    logic              r_cv_w;
    logic              r_cv_b;
    logic [15:0]       r_ca_w;
    logic [15:0]       r_ca_b;
    logic [DATA_W-1:0] r_cd_w;
    logic [DATA_W-1:0] r_cd_b;
    logic [15:0]       r_fetch_addr;

    // A hit is only safe when nothing older is queued or returning on that channel.
    assign w_hit_w = w_acc_w & r_cv_w & (r_ca_w == read_weight_addr) &
                     ~r_pend_w & ~w_ret_w & ~layer_start;
    assign w_hit_b = w_acc_b & r_cv_b & (r_ca_b == read_bias_addr) &
                     ~r_pend_b & ~w_ret_b & ~layer_start;
    assign w_cd_w  = r_cd_w;
    assign w_cd_b  = r_cd_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cv_w       <= 1'b0;
            r_cv_b       <= 1'b0;
            r_ca_w       <= '0;
            r_ca_b       <= '0;
            r_cd_w       <= '0;
            r_cd_b       <= '0;
            r_fetch_addr <= '0;
        end else begin
            r_fetch_addr <= w_grant_b ? r_addr_b : r_addr_w;
            if (w_ret_w) begin
                r_cv_w <= 1'b1;
                r_ca_w <= r_fetch_addr;
                r_cd_w <= mem_rdata;
            end
            if (w_ret_b) begin
                r_cv_b <= 1'b1;
                r_ca_b <= r_fetch_addr;
                r_cd_b <= mem_rdata;
            end
            if (layer_start) begin
                r_cv_w <= 1'b0;
                r_cv_b <= 1'b0;
            end
        end
    end
`else
    logic w_unused_layer_start;

    assign w_hit_w              = 1'b0;
    assign w_hit_b              = 1'b0;
    assign w_cd_w               = '0;
    assign w_cd_b               = '0;
    assign w_unused_layer_start = layer_start;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_w     <= 1'b0;
            r_pend_b     <= 1'b0;
            r_addr_w     <= '0;
            r_addr_b     <= '0;
            r_fetch_vld  <= 1'b0;
            r_fetch_b    <= 1'b0;
            weight_valid <= 1'b0;
            weight_data  <= '0;
            bias_valid   <= 1'b0;
            bias_data    <= '0;
            req_drop_err <= 1'b0;
        end else begin
            // A refill in the grant cycle wins over the clear.
            if (w_acc_w && !w_hit_w) begin
                r_pend_w <= 1'b1;
                r_addr_w <= read_weight_addr;
            end else if (w_grant_w) begin
                r_pend_w <= 1'b0;
            end
            if (w_acc_b && !w_hit_b) begin
                r_pend_b <= 1'b1;
                r_addr_b <= read_bias_addr;
            end else if (w_grant_b) begin
                r_pend_b <= 1'b0;
            end

            r_fetch_vld <= mem_cs;
            r_fetch_b   <= w_grant_b;

            weight_valid <= w_ret_w | w_hit_w;
            if (w_ret_w) begin
                weight_data <= mem_rdata;
            end else if (w_hit_w) begin
                weight_data <= w_cd_w;
            end
            bias_valid <= w_ret_b | w_hit_b;
            if (w_ret_b) begin
                bias_data <= mem_rdata;
            end else if (w_hit_b) begin
                bias_data <= w_cd_b;
            end

            if ((read_weight_signal && !weight_ready) || (read_bias_signal && !bias_ready)) begin
                req_drop_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_weight_bias_responder.sv
// Bench for weight_bias_responder: per-cycle vector table plus stress and latency sequences.
module tb_weight_bias_responder;
    logic        clk;
    logic        rst_n;
    logic        rw;
    logic [15:0] aw;
    logic        rb;
    logic [15:0] ab;
    logic        ls;
    logic        weight_ready;
    logic        bias_ready;
    logic [15:0] weight_data;
    logic        weight_valid;
    logic [15:0] bias_data;
    logic        bias_valid;
    logic        req_drop_err;
    logic        mem_cs;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;

    int checks;
    int errors;
    logic mon_en;
    logic [15:0] exp_q[$];

`ifdef WB_LAST_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    typedef struct {
        logic        rst_n;
        logic        rw;
        logic [15:0] aw;
        logic        rb;
        logic [15:0] ab;
        logic        cs;
        logic [15:0] addr;
        logic        wr;
        logic        br;
        logic        wv;
        logic [15:0] wd;
        logic        bv;
        logic [15:0] bd;
        logic        err;
    } vec_t;

    vec_t vecs[24];
    logic exp_wr[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic exp_err[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    weight_bias_responder dut (
        .clk                (clk),
        .rst                (rst_n),
        .read_weight_signal (rw),
        .read_weight_addr   (aw),
        .read_bias_signal   (rb),
        .read_bias_addr     (ab),
        .layer_start        (ls),
        .weight_ready       (weight_ready),
        .bias_ready         (bias_ready),
        .weight_data        (weight_data),
        .weight_valid       (weight_valid),
        .bias_data          (bias_data),
        .bias_valid         (bias_valid),
        .req_drop_err       (req_drop_err),
        .mem_cs             (mem_cs),
        .mem_addr           (mem_addr),
        .mem_rdata          (mem_rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM contents model: one-cycle read latency, junk when not selected
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a == 16'h0010) ? 16'h1234 : (a ^ 16'h5A5A);
    endfunction

    always_ff @(posedge clk) begin
        mem_rdata <= mem_cs ? mem_fn(mem_addr) : 16'hDEAD;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // scoreboard for in-order weight returns
    always @(negedge clk) begin
        if (mon_en && weight_valid) begin
            if (exp_q.size() == 0) begin
                chk("stress_unexpected_wvalid", 32'(weight_valid), 32'(0));
            end else begin
                chk("stress_wdata_order", 32'(weight_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic measure_w(input logic [15:0] addr, input int exp_lat, input int exp_cs,
                             input string nm);
        int lat;
        int cs_n;
        lat  = -1;
        cs_n = 0;
        @(posedge clk); #1;
        rw = 1'b1;
        aw = addr;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_cs) cs_n = cs_n + 1;
            if (weight_valid && lat < 0) begin
                lat = k;
                chk({nm, "_data"}, 32'(weight_data), 32'(mem_fn(addr)));
            end
            @(posedge clk); #1;
            rw = 1'b0;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_mem_cs_count"}, 32'(cs_n), 32'(exp_cs));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        rw = 1'b0; aw = '0; rb = 1'b0; ab = '0; ls = 1'b0;

        //           rst   rw    aw        rb    ab        cs    addr      wr    br    wv    wd        bv    bd        err
        vecs[0]  = '{1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h8002, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b1, 16'hDA58, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h5A5E, 1'b0, 16'hDA58, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h9000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h5A5E, 1'b0, 16'hDA58, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1000, 1'b1, 1'b1, 1'b0, 16'h5A5E, 1'b0, 16'hDA58, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h5A5E, 1'b0, 16'hDA58, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h5A5E, 1'b1, 16'h4A5A, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h5A5E, 1'b0, 16'h4A5A, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 16'h0101, 1'b0, 16'h0000, 1'b1, 16'h8200, 1'b0, 1'b1, 1'b0, 16'h5A5E, 1'b0, 16'h4A5A, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b1, 1'b1, 1'b0, 16'h5A5E, 1'b0, 16'h4A5A, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h5A5E, 1'b1, 16'hD85A, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h5B5A, 1'b0, 16'hD85A, 1'b1};
        vecs[19] = '{1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h5B5A, 1'b0, 16'hD85A, 1'b1};
        vecs[20] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b1, 1'b0, 16'h5B5A, 1'b0, 16'hD85A, 1'b1};
        vecs[21] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[23] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};

        // reset values while reset is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wready", 32'(weight_ready), 32'(1));
        chk("rst_bready", 32'(bias_ready), 32'(1));
        chk("rst_mem_cs", 32'(mem_cs), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_wvalid", 32'(weight_valid), 32'(0));
        chk("rst_bvalid", 32'(bias_valid), 32'(0));
        chk("rst_wdata", 32'(weight_data), 32'(0));
        chk("rst_bdata", 32'(bias_data), 32'(0));
        chk("rst_err", 32'(req_drop_err), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // directed per-cycle vectors
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            rst_n = vecs[i].rst_n;
            rw    = vecs[i].rw;
            aw    = vecs[i].aw;
            rb    = vecs[i].rb;
            ab    = vecs[i].ab;
            @(negedge clk);
            chk($sformatf("vec%0d_mem_cs", i), 32'(mem_cs), 32'(vecs[i].cs));
            chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d_wready", i), 32'(weight_ready), 32'(vecs[i].wr));
            chk($sformatf("vec%0d_bready", i), 32'(bias_ready), 32'(vecs[i].br));
            chk($sformatf("vec%0d_wvalid", i), 32'(weight_valid), 32'(vecs[i].wv));
            chk($sformatf("vec%0d_wdata", i), 32'(weight_data), 32'(vecs[i].wd));
            chk($sformatf("vec%0d_bvalid", i), 32'(bias_valid), 32'(vecs[i].bv));
            chk($sformatf("vec%0d_bdata", i), 32'(bias_data), 32'(vecs[i].bd));
            chk($sformatf("vec%0d_err", i), 32'(req_drop_err), 32'(vecs[i].err));
        end

        // weight every cycle, bias every other cycle: odd-cycle weights are dropped
        exp_q = {mem_fn(16'h0040), mem_fn(16'h0042), mem_fn(16'h0044), mem_fn(16'h0046)};
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            rw = 1'b1;
            aw = 16'h0040 + 16'(i);
            rb = (i % 2 == 0);
            ab = 16'(i);
            @(negedge clk);
            chk($sformatf("stress%0d_wready", i), 32'(weight_ready), 32'(exp_wr[i]));
            chk($sformatf("stress%0d_err", i), 32'(req_drop_err), 32'(exp_err[i]));
        end
        @(posedge clk); #1;
        rw = 1'b0;
        rb = 1'b0;
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        chk("stress_all_returned", 32'(exp_q.size()), 32'(0));

        // repeated address, then layer change
        measure_w(16'h0020, 3, 1, "first_0020");
        measure_w(16'h0020, CACHE ? 1 : 3, CACHE ? 0 : 1, "repeat_0020");
        @(posedge clk); #1;
        ls = 1'b1;
        @(posedge clk); #1;
        ls = 1'b0;
        measure_w(16'h0020, 3, 1, "after_layer_0020");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
